// File: rtl/framebuffer_scan_controller_pkg.sv
// Shared types and sizing helpers for the HUB75 framebuffer scan controller.
package framebuffer_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLK_HI  = 3'd2,
    CLK_LO  = 3'd3,
    WAIT_ON = 3'd4,
    BLANK   = 3'd5,
    LATCH   = 3'd6
  } scan_state_t;

  localparam int PIXEL_WIDTH_DEF  = 64;
  localparam int PIXEL_HEIGHT_DEF = 16;
  localparam int COL_W = $clog2(PIXEL_WIDTH_DEF);
  localparam int ROW_W = $clog2(PIXEL_HEIGHT_DEF);

  function automatic int on_cnt_width(input int on_time);
    return $clog2(on_time + 1);
  endfunction

endpackage

// File: rtl/framebuffer_scan_controller_timeout.sv
// Dwell timer: count tracks dwell cycles left including the current one, and
// running stays high while more than the current cycle remains after a start.
module framebuffer_scan_controller_timeout #(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] value,
  output logic                     running
);

  logic [COUNTER_WIDTH-1:0] count_r;
  logic [COUNTER_WIDTH-1:0] count_nxt_s;

  // Next count: the start cycle itself is one of the value cycles.
  always_comb begin
    count_nxt_s = count_r;
    if (start) begin
      count_nxt_s = value - COUNTER_WIDTH'(1);
    end else if (count_r != {COUNTER_WIDTH{1'b0}}) begin
      count_nxt_s = count_r - COUNTER_WIDTH'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register and registered running flag.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_r <= {COUNTER_WIDTH{1'b0}};
      running <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      running <= (count_nxt_s > COUNTER_WIDTH'(1));
    end
  end

endmodule

// File: rtl/framebuffer_scan_controller.sv
// HUB75 scan sequencer: fetches and shifts row r+1 while row r is lit, then
// blanks, latches and reloads the per-row on-time counter.
module framebuffer_scan_controller
  import framebuffer_scan_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 64,
  parameter int PIXEL_HEIGHT = 16,
  parameter int LOAD_CYCLES  = 3,
  parameter int ON_TIME      = 256
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            enable,
  output logic [$clog2(PIXEL_WIDTH)-1:0]  column_address,
  output logic [$clog2(PIXEL_HEIGHT)-1:0] row_address,
  output logic                            pixel_load_start,
  output logic                            pixel_clk,
  output logic                            latch,
  output logic                            oe_n,
  output logic [$clog2(PIXEL_HEIGHT)-1:0] row_select,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int COL_BITS = $clog2(PIXEL_WIDTH);
  localparam int ROW_BITS = $clog2(PIXEL_HEIGHT);
  localparam int CNT_BITS = on_cnt_width(ON_TIME);

  scan_state_t         state_r;
  logic                lit_r;
  logic [CNT_BITS-1:0] on_cnt_r;
  logic                load_running_s;
  logic                load_done_s;

  framebuffer_scan_controller_timeout #(
    .COUNTER_WIDTH(4)
  ) u_load_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (pixel_load_start),
    .value   (4'(LOAD_CYCLES)),
    .running (load_running_s)
  );

  // The strobe cycle is the first LOAD cycle, so a one-cycle dwell ends right there.
  always_comb begin
    load_done_s = 1'b0;
    if (pixel_load_start) begin
      load_done_s = (LOAD_CYCLES == 1);
    end else begin
      load_done_s = !load_running_s;
    end
  end

  // Scan FSM with registered panel and fetch outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r          <= IDLE;
      column_address   <= {COL_BITS{1'b0}};
      row_address      <= {ROW_BITS{1'b0}};
      pixel_load_start <= 1'b0;
      pixel_clk        <= 1'b0;
      latch            <= 1'b0;
      oe_n             <= 1'b1;
      row_select       <= {ROW_BITS{1'b0}};
      frame_done       <= 1'b0;
      busy             <= 1'b0;
      lit_r            <= 1'b0;
      on_cnt_r         <= {CNT_BITS{1'b0}};
    end else begin
      pixel_load_start <= 1'b0;
      pixel_clk        <= 1'b0;
      latch            <= 1'b0;
      frame_done       <= 1'b0;
      if (!oe_n && on_cnt_r != {CNT_BITS{1'b0}}) begin
        on_cnt_r <= on_cnt_r - CNT_BITS'(1);
      end
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r          <= LOAD;
            pixel_load_start <= 1'b1;
            oe_n             <= ~lit_r;
            busy             <= 1'b1;
          end else begin
            oe_n <= 1'b1;
            busy <= 1'b0;
          end
        end
        LOAD: begin
          oe_n <= ~lit_r;
          if (load_done_s) begin
            state_r   <= CLK_HI;
            pixel_clk <= 1'b1;
          end
        end
        CLK_HI: begin
          state_r <= CLK_LO;
          oe_n    <= ~lit_r;
        end
        CLK_LO: begin
          oe_n <= ~lit_r;
          if (column_address == COL_BITS'(PIXEL_WIDTH - 1)) begin
            column_address <= {COL_BITS{1'b0}};
            state_r        <= WAIT_ON;
          end else begin
            column_address   <= column_address + COL_BITS'(1);
            state_r          <= LOAD;
            pixel_load_start <= 1'b1;
          end
        end
        WAIT_ON: begin
          if (on_cnt_r == {CNT_BITS{1'b0}}) begin
            state_r <= BLANK;
            oe_n    <= 1'b1;
          end else begin
            oe_n <= ~lit_r;
          end
        end
        BLANK: begin
          state_r    <= LATCH;
          latch      <= 1'b1;
          frame_done <= (row_address == ROW_BITS'(PIXEL_HEIGHT - 1));
          oe_n       <= 1'b1;
        end
        LATCH: begin
          // Reload wins over the decrement scheduled above.
          row_select  <= row_address;
          row_address <= row_address + ROW_BITS'(1);
          lit_r       <= 1'b1;
          on_cnt_r    <= CNT_BITS'(ON_TIME);
          if (enable) begin
            state_r          <= LOAD;
            pixel_load_start <= 1'b1;
            oe_n             <= 1'b0;
          end else begin
            state_r <= IDLE;
            oe_n    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          oe_n    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_scan_controller.sv
// Directed bench: three small scan controllers with hand-timed event ticks.
module tb_framebuffer_scan_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b, en_c;

  logic [1:0] a_col, b_col, c_col;
  logic       a_row, b_row, c_row, a_rsel, b_rsel, c_rsel;
  logic       a_pls, a_pclk, a_latch, a_oe, a_fd, a_busy;
  logic       b_pls, b_pclk, b_latch, b_oe, b_fd, b_busy;
  logic       c_pls, c_pclk, c_latch, c_oe, c_fd, c_busy;

  bit [127:0] ah_pls, ah_pclk, ah_latch, ah_oe_low, ah_fd;
  bit [127:0] bh_latch, bh_oe_low, bh_fd;
  bit [127:0] ch_pls, ch_latch, ch_fd;
  int         ah_col [128];
  int         ah_row [128];
  int         ah_rsel[128];
  int         ah_busy[128];
  int         ah_oe  [128];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  framebuffer_scan_controller #(.PIXEL_WIDTH(4), .PIXEL_HEIGHT(2), .LOAD_CYCLES(3), .ON_TIME(8)) u_a (
    .clk_in(clk), .reset(rst_n), .enable(en_a), .column_address(a_col), .row_address(a_row),
    .pixel_load_start(a_pls), .pixel_clk(a_pclk), .latch(a_latch), .oe_n(a_oe),
    .row_select(a_rsel), .frame_done(a_fd), .busy(a_busy));

  framebuffer_scan_controller #(.PIXEL_WIDTH(4), .PIXEL_HEIGHT(2), .LOAD_CYCLES(3), .ON_TIME(40)) u_b (
    .clk_in(clk), .reset(rst_n), .enable(en_b), .column_address(b_col), .row_address(b_row),
    .pixel_load_start(b_pls), .pixel_clk(b_pclk), .latch(b_latch), .oe_n(b_oe),
    .row_select(b_rsel), .frame_done(b_fd), .busy(b_busy));

  framebuffer_scan_controller #(.PIXEL_WIDTH(4), .PIXEL_HEIGHT(2), .LOAD_CYCLES(1), .ON_TIME(8)) u_c (
    .clk_in(clk), .reset(rst_n), .enable(en_c), .column_address(c_col), .row_address(c_row),
    .pixel_load_start(c_pls), .pixel_clk(c_pclk), .latch(c_latch), .oe_n(c_oe),
    .row_select(c_rsel), .frame_done(c_fd), .busy(c_busy));

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int count_range(input bit [127:0] v, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic record(input int t);
    ah_pls[t] = a_pls;   ah_pclk[t] = a_pclk; ah_latch[t] = a_latch;
    ah_oe_low[t] = !a_oe; ah_fd[t] = a_fd;
    ah_col[t] = int'(a_col); ah_row[t] = int'(a_row); ah_rsel[t] = int'(a_rsel);
    ah_busy[t] = int'(a_busy); ah_oe[t] = int'(a_oe);
    bh_latch[t] = b_latch; bh_oe_low[t] = !b_oe; bh_fd[t] = b_fd;
    ch_pls[t] = c_pls; ch_latch[t] = c_latch; ch_fd[t] = c_fd;
  endtask

  initial begin
    int first_low;
    int consec;
    rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_col",   a_col,   0);
    check_value("rst_row",   a_row,   0);
    check_value("rst_pls",   a_pls,   0);
    check_value("rst_pclk",  a_pclk,  0);
    check_value("rst_latch", a_latch, 0);
    check_value("rst_oe_n",  a_oe,    1);
    check_value("rst_rsel",  a_rsel,  0);
    check_value("rst_fd",    a_fd,    0);
    check_value("rst_busy",  a_busy,  0);
    rst_n = 1'b1;

    // Tick t is sampled 1 time unit after the t-th rising edge after release.
    for (int t = 1; t <= 119; t++) begin
      @(posedge clk);
      #1;
      record(t);
      if (t == 80)  en_a = 1'b0;
      if (t == 110) en_a = 1'b1;
    end

    // First row shift of u_a: strobes 5 cycles apart, latch after WAIT_ON + BLANK.
    check_value("a_pls_count_row0", count_range(ah_pls, 1, 20), 4);
    check_value("a_pls_t1",  ah_pls[1],  1);
    check_value("a_pls_t6",  ah_pls[6],  1);
    check_value("a_pls_t11", ah_pls[11], 1);
    check_value("a_pls_t16", ah_pls[16], 1);
    check_value("a_col_t11", ah_col[11], 2);
    check_value("a_pclk_count_row0", count_range(ah_pclk, 1, 20), 4);
    check_value("a_pclk_t4", ah_pclk[4], 1);
    check_value("a_latch_t23", ah_latch[23], 1);
    check_value("a_latch_before23", count_range(ah_latch, 1, 22), 0);
    first_low = 0;
    for (int t = 119; t >= 1; t--) if (ah_oe_low[t]) first_low = t;
    check_value("a_oe_first_low", first_low, 24);
    check_value("a_rsel_t24", ah_rsel[24], 0);
    check_value("a_row_t24",  ah_row[24], 1);
    check_value("a_pls_t24",  ah_pls[24], 1);

    // Row wrap: only the row 1 latch pulses frame_done.
    check_value("a_fd_t23", ah_fd[23], 0);
    check_value("a_fd_t46", ah_fd[46], 1);
    check_value("a_fd_t47", ah_fd[47], 0);
    check_value("a_row_t47", ah_row[47], 0);
    check_value("a_rsel_t47", ah_rsel[47], 1);
    check_value("a_fd_t69", ah_fd[69], 0);

    // Long on-time: second shift leaves 20 cycles, WAIT_ON stretches with oe_n low.
    check_value("b_latch_t23", bh_latch[23], 1);
    check_value("b_oe_low_24_64", count_range(bh_oe_low, 24, 64), 41);
    check_value("b_oe_t65_blank", bh_oe_low[65], 0);
    check_value("b_latch_t66", bh_latch[66], 1);
    check_value("b_latch_24_65", count_range(bh_latch, 24, 65), 0);
    check_value("b_fd_t66", bh_fd[66], 1);

    // Enable dropped in column 2 of row 1: row completes then IDLE.
    check_value("a_col_t80", ah_col[80], 2);
    check_value("a_pls_80_92", count_range(ah_pls, 80, 92), 2);
    check_value("a_pls_t85", ah_pls[85], 1);
    check_value("a_pclk_81_92", count_range(ah_pclk, 81, 92), 2);
    check_value("a_latch_t92", ah_latch[92], 1);
    check_value("a_fd_t92", ah_fd[92], 1);
    check_value("a_busy_t93", ah_busy[93], 0);
    check_value("a_oe_t93", ah_oe[93], 1);
    check_value("a_pls_93_110", count_range(ah_pls, 93, 110), 0);
    check_value("a_busy_t110", ah_busy[110], 0);

    // Re-enable from IDLE: row stays lit, oe_n low again in LOAD.
    check_value("a_pls_t111", ah_pls[111], 1);
    check_value("a_oe_t111", ah_oe[111], 0);
    check_value("a_row_t111", ah_row[111], 0);
    check_value("a_pls_t116", ah_pls[116], 1);

    // LOAD_CYCLES=1: 3-cycle column period, never back-to-back strobes.
    check_value("c_pls_count_row0", count_range(ch_pls, 1, 12), 4);
    check_value("c_pls_t4",  ch_pls[4],  1);
    check_value("c_pls_t10", ch_pls[10], 1);
    check_value("c_latch_t15", ch_latch[15], 1);
    check_value("c_latch_count", count_range(ch_latch, 1, 110), 7);
    check_value("c_fd_count", count_range(ch_fd, 1, 110), 3);
    consec = 0;
    for (int t = 1; t < 119; t++) consec += int'(ch_pls[t] & ch_pls[t+1]);
    check_value("c_pls_consecutive", consec, 0);

    // Asynchronous reset in CLK_HI of column 1.
    check_value("a_pclk_t119", a_pclk, 1);
    check_value("a_col_t119", a_col, 1);
    check_value("a_rsel_t119", a_rsel, 1);
    rst_n = 1'b0;
    #1;
    check_value("arst_pclk", a_pclk, 0);
    check_value("arst_oe_n", a_oe, 1);
    check_value("arst_col",  a_col, 0);
    check_value("arst_row",  a_row, 0);
    check_value("arst_rsel", a_rsel, 0);
    check_value("arst_busy", a_busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("restart_pls",  a_pls, 1);
    check_value("restart_col",  a_col, 0);
    check_value("restart_row",  a_row, 0);
    check_value("restart_oe_n", a_oe, 1);
    check_value("restart_busy", a_busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
